// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: video fetch and CPU share one controller command port,
// one transaction in flight, video preferred with a bounded streak against a waiting CPU.
module sdram_arbiter #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_ack,
  output logic [DATA_W-1:0]   vid_rdata,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic                cpu_ack,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_done,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state, state_d;
  logic                owner_cpu, owner_cpu_d;
  logic [STREAK_W-1:0] streak, streak_d;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [BE_W-1:0]     mem_be_d;
  logic                vid_ack_d, cpu_ack_d;
  logic [DATA_W-1:0]   vid_rdata_d, cpu_rdata_d;
  logic                mem_cmd_valid_d, busy_d;

  logic vid_elig, cpu_elig, cpu_first, grant_vid, grant_cpu;

  // A requester is not eligible in the cycle its own ack is being pulsed.
  // Video is the arbitration winner whenever it requests unless the CPU has
  // been starved for MAX_STREAK grants; a winner blocked by its ack yields no grant.
  always_comb begin
    vid_elig  = vid_req && !vid_ack;
    cpu_elig  = cpu_req && !cpu_ack;
    cpu_first = cpu_elig && (streak == STREAK_W'(MAX_STREAK));
    grant_cpu = cpu_elig && (cpu_first || !vid_req);
    grant_vid = vid_elig && !cpu_first;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state;
    owner_cpu_d = owner_cpu;
    streak_d    = streak;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata;
    cpu_rdata_d = cpu_rdata;

    case (state)
      IDLE: begin
        if (grant_cpu) begin
          owner_cpu_d = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_be_d    = cpu_be;
          streak_d    = '0;
          state_d     = ISSUE;
        end else if (grant_vid) begin
          owner_cpu_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = vid_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          if (!cpu_req)
            streak_d = '0;
          else if (streak != STREAK_W'(MAX_STREAK))
            streak_d = streak + STREAK_W'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_cmd_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          state_d = IDLE;
          if (owner_cpu) begin
            cpu_ack_d = 1'b1;
            if (!mem_we)
              cpu_rdata_d = mem_rdata;
          end else begin
            vid_ack_d   = 1'b1;
            vid_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mem_cmd_valid_d = (state_d == ISSUE);
    busy_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner_cpu     <= 1'b0;
      streak        <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      vid_ack       <= 1'b0;
      cpu_ack       <= 1'b0;
      vid_rdata     <= '0;
      cpu_rdata     <= '0;
      mem_cmd_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      owner_cpu     <= owner_cpu_d;
      streak        <= streak_d;
      mem_we        <= mem_we_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      mem_be        <= mem_be_d;
      vid_ack       <= vid_ack_d;
      cpu_ack       <= cpu_ack_d;
      vid_rdata     <= vid_rdata_d;
      cpu_rdata     <= cpu_rdata_d;
      mem_cmd_valid <= mem_cmd_valid_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a per-cycle vector table for basic reads, then
// directed sequences for write stall, streak fairness, ack-cycle hold and reset.
module tb_sdram_arbiter;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              rst;
    logic              vid_req;
    logic              cpu_req;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata_in;
    logic              e_busy;
    logic              e_valid;
    logic              e_vack;
    logic              e_cack;
    logic [DATA_W-1:0] e_vrd;
    logic [DATA_W-1:0] e_crd;
  } vec_t;

  vec_t vecs [11];
  logic grants [10];
  int   n_grants;
  int   valid_cnt;
  int   ack_cnt;

  initial begin
    // rst vreq creq rdy done rdata_in | busy valid vack cack vid_rdata cpu_rdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF};

    rst = 1'b1; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    vid_addr = 24'h000100; cpu_addr = 24'h000010; cpu_wdata = '0; cpu_be = '1;
    mem_cmd_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;

    // Reset, single CPU read, single video read, spurious done/ready in IDLE
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; vid_req = vecs[i].vid_req; cpu_req = vecs[i].cpu_req;
      mem_cmd_ready = vecs[i].ready; mem_done = vecs[i].done; mem_rdata = vecs[i].rdata_in;
      step();
      check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("vec%0d mem_cmd_valid", i), 64'(mem_cmd_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d vid_ack", i), 64'(vid_ack), 64'(vecs[i].e_vack));
      check($sformatf("vec%0d cpu_ack", i), 64'(cpu_ack), 64'(vecs[i].e_cack));
      check($sformatf("vec%0d vid_rdata", i), 64'(vid_rdata), 64'(vecs[i].e_vrd));
      check($sformatf("vec%0d cpu_rdata", i), 64'(cpu_rdata), 64'(vecs[i].e_crd));
      if (i == 1) check("vec1 mem_addr", 64'(mem_addr), 64'h10);
      if (i == 5) check("vec5 mem_addr", 64'(mem_addr), 64'h100);
    end
    mem_cmd_ready = 1'b0; mem_done = 1'b0;

    // CPU write stalled 5 cycles by the controller; request changes mid-flight
    cpu_we = 1'b1; cpu_be = 4'b0011; cpu_wdata = 32'h12345678; cpu_addr = 24'h000020;
    cpu_req = 1'b1; mem_rdata = 32'h55555555;
    step();
    valid_cnt = 0;
    for (int i = 0; i < 8 && mem_cmd_valid; i++) begin
      check("wr mem_we", 64'(mem_we), 64'h1);
      check("wr mem_addr", 64'(mem_addr), 64'h20);
      check("wr mem_wdata", 64'(mem_wdata), 64'h12345678);
      check("wr mem_be", 64'(mem_be), 64'h3);
      if (i == 0) begin
        cpu_addr = 24'h000000; cpu_wdata = '0; cpu_be = '1;
      end
      mem_cmd_ready = (i == 5);
      step();
      valid_cnt++;
    end
    mem_cmd_ready = 1'b0;
    check("wr valid cycles", 64'(valid_cnt), 64'd6);
    check("wr wait valid", 64'(mem_cmd_valid), 64'h0);
    check("wr wait busy", 64'(busy), 64'h1);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0; cpu_req = 1'b0;
    check("wr cpu_ack", 64'(cpu_ack), 64'h1);
    check("wr cpu_rdata kept", 64'(cpu_rdata), 64'hDEADBEEF);
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cpu_ack) ack_cnt++;
    end
    check("wr extra acks", 64'(ack_cnt), 64'h0);

    // Both requesters held: grant order V,V,V,V,C,V,V,V,V,C
    cpu_we = 1'b0; cpu_addr = 24'h000010; cpu_be = '1;
    mem_cmd_ready = 1'b1; mem_done = 1'b1;
    vid_req = 1'b1; cpu_req = 1'b1;
    n_grants = 0;
    for (int c = 0; c < 200 && n_grants < 10; c++) begin
      step();
      if (mem_cmd_valid) begin
        grants[n_grants] = (mem_addr == 24'h000010);
        if (!grants[n_grants]) begin
          check("vid grant mem_we", 64'(mem_we), 64'h0);
          check("vid grant mem_be", 64'(mem_be), 64'hF);
        end
        n_grants++;
      end
    end
    check("streak grant count", 64'(n_grants), 64'd10);
    for (int k = 0; k < n_grants; k++)
      check($sformatf("streak grant%0d is_cpu", k), 64'(grants[k]), 64'((k == 4) || (k == 9)));
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (6) step();
    mem_cmd_ready = 1'b0; mem_done = 1'b0;
    check("streak drained busy", 64'(busy), 64'h0);

    // Video holds req during its ack cycle: one idle cycle, then regrant
    vid_req = 1'b1; mem_cmd_ready = 1'b1; mem_done = 1'b1;
    step();
    check("hold issue busy", 64'(busy), 64'h1);
    step();
    step();
    check("hold ack vid_ack", 64'(vid_ack), 64'h1);
    check("hold ack busy", 64'(busy), 64'h0);
    step();
    check("hold idle busy", 64'(busy), 64'h0);
    check("hold idle valid", 64'(mem_cmd_valid), 64'h0);
    check("hold idle vid_ack", 64'(vid_ack), 64'h0);
    step();
    check("hold regrant valid", 64'(mem_cmd_valid), 64'h1);
    vid_req = 1'b0;
    repeat (4) step();
    mem_cmd_ready = 1'b0; mem_done = 1'b0;

    // Reset in WAIT abandons the transaction; the late mem_done is ignored
    cpu_req = 1'b1; mem_cmd_ready = 1'b1;
    step();
    step();
    check("rst pre busy", 64'(busy), 64'h1);
    check("rst pre valid", 64'(mem_cmd_valid), 64'h0);
    rst = 1'b1; cpu_req = 1'b0; mem_cmd_ready = 1'b0;
    step();
    check("rst busy", 64'(busy), 64'h0);
    check("rst cpu_rdata", 64'(cpu_rdata), 64'h0);
    check("rst vid_rdata", 64'(vid_rdata), 64'h0);
    check("rst mem_addr", 64'(mem_addr), 64'h0);
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_done = 1'b0;
    check("post rst cpu_ack", 64'(cpu_ack), 64'h0);
    check("post rst vid_ack", 64'(vid_ack), 64'h0);
    check("post rst busy", 64'(busy), 64'h0);
    check("post rst valid", 64'(mem_cmd_valid), 64'h0);
    check("post rst cpu_rdata", 64'(cpu_rdata), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
